// File: rtl/vga_rect_filler_if.sv
// Bus bundle for the rectangle filler: CPU register port, SDRAM write master, irq.
// The slave modport is the filler's own view. The master modport is the view of the
// CPU/fabric that drives the register port and answers the write master.
interface vga_rect_filler_if;
    // Register (slave) port
    logic [2:0]  slave_address;
    logic        slave_chipselect;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    // Write master toward SDRAM
    logic [31:0] master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [3:0]  master_byteenable;
    logic        master_waitrequest;
    // Completion interrupt
    logic        irq;

    modport slave (
        input  slave_address, slave_chipselect, slave_write, slave_writedata,
        input  master_waitrequest,
        output slave_readdata,
        output master_address, master_write, master_writedata, master_byteenable,
        output irq
    );

    modport master (
        output slave_address, slave_chipselect, slave_write, slave_writedata,
        output master_waitrequest,
        input  slave_readdata,
        input  master_address, master_write, master_writedata, master_byteenable,
        input  irq
    );
endinterface

// File: rtl/vga_rect_filler.sv
// Fills an axis-aligned rectangle of the RGB565 framebuffer (2 pixels/word) with one colour.
// Latency: go write at N, first master_write at N+3, then 1 word/clk, 1 idle cycle per row.
// Backpressure: master_waitrequest holds address/data/byteenable until the word is accepted.
module vga_rect_filler #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_rect_filler_if.slave  bus
);

    localparam logic [10:0] H_LIM  = 11'(H_RES);
    localparam logic [10:0] V_LIM  = 11'(V_RES);
    localparam logic [31:0] STRIDE = 32'(H_RES * 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ROW,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // CPU-visible registers
    logic        irq_en_q,  irq_en_d;
    logic [29:0] fb_base_q, fb_base_d;
    logic [9:0]  x0_q,      x0_d;
    logic [9:0]  y0_q,      y0_d;
    logic [10:0] w_q,       w_d;
    logic [10:0] h_q,       h_d;
    logic [15:0] colour_q,  colour_d;

    // Status
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        error_q,   error_d;
    logic        irq_q,     irq_d;

    // Shadow state of the running fill, captured in SETUP
    logic [31:0] row_ptr_q,   row_ptr_d;
    logic [9:0]  xs_q,        xs_d;
    logic [9:0]  xe_q,        xe_d;
    logic [9:0]  xcur_q,      xcur_d;
    logic [10:0] rows_left_q, rows_left_d;
    logic [3:0]  first_be_q,  first_be_d;
    logic [3:0]  last_be_q,   last_be_d;
    logic [15:0] sh_colour_q, sh_colour_d;

    // Registered master outputs
    logic [31:0] m_addr_q,  m_addr_d;
    logic        m_write_q, m_write_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_be_q,    m_be_d;

    // Geometry derived from the live registers, only consumed in SETUP
    logic        reg_wr;
    logic        go;
    logic [10:0] x0_ext;
    logic [10:0] y0_ext;
    logic        reject;
    logic [10:0] w_room;
    logic [10:0] h_room;
    logic [10:0] w_clip;
    logic [10:0] h_clip;
    logic [10:0] x_last;
    logic [31:0] row_base;

    // Halfword enables for a word: trim the leading pixel on the first word and the
    // trailing pixel on the last word; a one-word row gets both trims.
    function automatic logic [3:0] be_at(
        input logic [9:0] idx,
        input logic [9:0] xs,
        input logic [9:0] xe,
        input logic [3:0] first_be,
        input logic [3:0] last_be
    );
        logic [3:0] be;
        be = 4'b1111;
        if (idx == xs) be = be & first_be;
        if (idx == xe) be = be & last_be;
        return be;
    endfunction

    // Rectangle validation, clipping to the frame and first-row address
    always_comb begin
        x0_ext   = {1'b0, x0_q};
        y0_ext   = {1'b0, y0_q};
        reject   = (x0_ext >= H_LIM) || (y0_ext >= V_LIM) || (w_q == 11'd0) || (h_q == 11'd0);
        w_room   = H_LIM - x0_ext;
        h_room   = V_LIM - y0_ext;
        w_clip   = (w_q < w_room) ? w_q : w_room;
        h_clip   = (h_q < h_room) ? h_q : h_room;
        x_last   = x0_ext + w_clip - 11'd1;
        row_base = {fb_base_q, 2'b00} + 32'(y0_q) * STRIDE;
    end

    // Register writes and the fill sequencer
    always_comb begin
        state_d     = state_q;
        irq_en_d    = irq_en_q;
        fb_base_d   = fb_base_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        colour_d    = colour_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        row_ptr_d   = row_ptr_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        xcur_d      = xcur_q;
        rows_left_d = rows_left_q;
        first_be_d  = first_be_q;
        last_be_d   = last_be_q;
        sh_colour_d = sh_colour_q;
        m_addr_d    = m_addr_q;
        m_write_d   = m_write_q;
        m_wdata_d   = m_wdata_q;
        m_be_d      = m_be_q;

        reg_wr = bus.slave_write & bus.slave_chipselect;
        go     = reg_wr && (bus.slave_address == 3'd0) && bus.slave_writedata[0];

        if (reg_wr) begin
            case (bus.slave_address)
                3'd0: begin
                    irq_en_d = bus.slave_writedata[1];
                    if (bus.slave_writedata[2]) begin
                        done_d  = 1'b0;
                        error_d = 1'b0;
                    end
                end
                3'd1: fb_base_d = bus.slave_writedata[31:2];
                3'd2: begin
                    x0_d = bus.slave_writedata[9:0];
                    y0_d = bus.slave_writedata[25:16];
                end
                3'd3: begin
                    w_d = bus.slave_writedata[10:0];
                    h_d = bus.slave_writedata[26:16];
                end
                3'd4: colour_d = bus.slave_writedata[15:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                sh_colour_d = colour_q;
                if (reject) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    xs_d        = x0_q >> 1;
                    xe_d        = x_last[10:1];
                    first_be_d  = x0_q[0]   ? 4'b1100 : 4'b1111;
                    last_be_d   = x_last[0] ? 4'b1111 : 4'b0011;
                    rows_left_d = h_clip;
                    row_ptr_d   = row_base;
                    state_d     = S_ROW;
                end
            end
            S_ROW: begin
                m_addr_d  = row_ptr_q + {20'd0, xs_q, 2'b00};
                m_be_d    = be_at(xs_q, xs_q, xe_q, first_be_q, last_be_q);
                m_wdata_d = {sh_colour_q, sh_colour_q};
                m_write_d = 1'b1;
                xcur_d    = xs_q;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                if (!bus.master_waitrequest) begin
                    if (xcur_q == xe_q) begin
                        m_write_d = 1'b0;
                        if (rows_left_q > 11'd1) begin
                            rows_left_d = rows_left_q - 11'd1;
                            row_ptr_d   = row_ptr_q + STRIDE;
                            state_d     = S_ROW;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        xcur_d   = xcur_q + 10'd1;
                        m_addr_d = m_addr_q + 32'd4;
                        m_be_d   = be_at(xcur_q + 10'd1, xs_q, xe_q, first_be_q, last_be_q);
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        irq_d = done_d & irq_en_d;
    end

    // State, registers and outputs; reset abandons any fill in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            irq_en_q    <= 1'b0;
            fb_base_q   <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            colour_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            irq_q       <= 1'b0;
            row_ptr_q   <= '0;
            xs_q        <= '0;
            xe_q        <= '0;
            xcur_q      <= '0;
            rows_left_q <= '0;
            first_be_q  <= '0;
            last_be_q   <= '0;
            sh_colour_q <= '0;
            m_addr_q    <= '0;
            m_write_q   <= 1'b0;
            m_wdata_q   <= '0;
            m_be_q      <= '0;
        end else begin
            state_q     <= state_d;
            irq_en_q    <= irq_en_d;
            fb_base_q   <= fb_base_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            colour_q    <= colour_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            irq_q       <= irq_d;
            row_ptr_q   <= row_ptr_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            xcur_q      <= xcur_d;
            rows_left_q <= rows_left_d;
            first_be_q  <= first_be_d;
            last_be_q   <= last_be_d;
            sh_colour_q <= sh_colour_d;
            m_addr_q    <= m_addr_d;
            m_write_q   <= m_write_d;
            m_wdata_q   <= m_wdata_d;
            m_be_q      <= m_be_d;
        end
    end

    // Register readback, decoded from address alone
    always_comb begin
        bus.slave_readdata = 32'd0;
        case (bus.slave_address)
            3'd0: bus.slave_readdata = {28'd0, error_q, done_q, irq_en_q, busy_q};
            3'd1: bus.slave_readdata = {fb_base_q, 2'b00};
            3'd2: bus.slave_readdata = {6'd0, y0_q, 6'd0, x0_q};
            3'd3: bus.slave_readdata = {5'd0, h_q, 5'd0, w_q};
            3'd4: bus.slave_readdata = {16'd0, colour_q};
            default: bus.slave_readdata = 32'd0;
        endcase
    end

    assign bus.master_address    = m_addr_q;
    assign bus.master_write      = m_write_q;
    assign bus.master_writedata  = m_wdata_q;
    assign bus.master_byteenable = m_be_q;
    assign bus.irq               = irq_q;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed bench: expected SDRAM writes are queued when a fill is launched and a
// negedge monitor pops/compares them as the filler presents words.
module tb_vga_rect_filler;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_rect_filler_if bus();

    vga_rect_filler #(.H_RES(640), .V_RES(480)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  acc_cnt = 0;
    int  stall_at = -1;
    int  stall_left = 0;
    int  stall_seen = 0;

    function automatic void chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Monitor: compare each presented word with the head of the expected queue
    always @(negedge clk) begin
        wr_t cur;
        wr_t e;
        if (reset_n && bus.master_write) begin
            cur = '{bus.master_address, bus.master_writedata, bus.master_byteenable};
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got %h, expected no write", cur);
            end else if (bus.master_waitrequest) begin
                stall_seen++;
                chk("stall_hold", cur, exp_q[0]);
            end else begin
                e = exp_q.pop_front();
                acc_cnt++;
                chk("write", cur, e);
            end
        end
    end

    // Slave stall generator: hold waitrequest while word number stall_at is presented
    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && acc_cnt == stall_at && bus.master_write) begin
            bus.master_waitrequest = 1'b1;
            stall_left--;
        end else begin
            bus.master_waitrequest = 1'b0;
        end
    end

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.slave_address    = a;
        bus.slave_writedata  = d;
        bus.slave_chipselect = 1'b1;
        bus.slave_write      = 1'b1;
        @(posedge clk); #1;
        bus.slave_chipselect = 1'b0;
        bus.slave_write      = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
        bus.slave_address = a;
        #1;
        d = bus.slave_readdata;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_q.push_back('{a, d, be});
    endtask

    task automatic start_fill(input logic [31:0] base, input int x0, input int y0,
                              input int w, input int h, input logic [15:0] colour,
                              input logic [31:0] ctrl);
        reg_wr(3'd1, base);
        reg_wr(3'd2, (32'(y0) << 16) | 32'(x0));
        reg_wr(3'd3, (32'(h) << 16) | 32'(w));
        reg_wr(3'd4, {16'd0, colour});
        acc_cnt = 0;
        reg_wr(3'd0, ctrl);
    endtask

    task automatic wait_idle(input string name, input logic [31:0] status);
        logic [31:0] r;
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            reg_rd(3'd0, r);
            n++;
        end while (r[0] && n < 2000);
        if (r[0]) begin
            n_chk++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
        end
        chk({name, "_drain"}, 68'(exp_q.size()), 68'd0);
        chk({name, "_status"}, 68'(r), 68'(status));
    endtask

    initial begin
        logic [31:0] r;
        bus.slave_address      = 3'd0;
        bus.slave_chipselect   = 1'b0;
        bus.slave_write        = 1'b0;
        bus.slave_writedata    = 32'd0;
        bus.master_waitrequest = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        reg_rd(3'd0, r);
        chk("rst_ctrl",  68'(r), 68'd0);
        chk("rst_irq",   68'(bus.irq), 68'd0);
        chk("rst_write", 68'(bus.master_write), 68'd0);
        chk("rst_addr",  68'(bus.master_address), 68'd0);
        chk("rst_be",    68'(bus.master_byteenable), 68'd0);
        chk("rst_wdata", 68'(bus.master_writedata), 68'd0);

        // Register readback: FB_BASE low bits read 0, unmapped address reads 0
        reg_wr(3'd1, 32'h0012_3457);
        reg_rd(3'd1, r);
        chk("fb_base_rd", 68'(r), 68'h0012_3454);
        reg_wr(3'd5, 32'hFFFF_FFFF);
        reg_rd(3'd5, r);
        chk("addr5_rd", 68'(r), 68'd0);

        // Even-aligned 4x2 fill
        push(32'h0010_0000, 32'hF800_F800, 4'hF);
        push(32'h0010_0004, 32'hF800_F800, 4'hF);
        push(32'h0010_0500, 32'hF800_F800, 4'hF);
        push(32'h0010_0504, 32'hF800_F800, 4'hF);
        start_fill(32'h0010_0000, 0, 0, 4, 2, 16'hF800, 32'h1);
        wait_idle("even", 32'h4);

        // Odd leading and even trailing pixel
        push(32'h0010_0504, 32'h07E0_07E0, 4'hC);
        push(32'h0010_0508, 32'h07E0_07E0, 4'hF);
        push(32'h0010_050C, 32'h07E0_07E0, 4'h3);
        start_fill(32'h0010_0000, 3, 1, 4, 1, 16'h07E0, 32'h5);
        wait_idle("odd", 32'h4);

        // Single pixel, odd then even position
        push(32'h0010_0008, 32'h001F_001F, 4'hC);
        start_fill(32'h0010_0000, 5, 0, 1, 1, 16'h001F, 32'h5);
        wait_idle("pix_odd", 32'h4);
        push(32'h0010_0008, 32'h001F_001F, 4'h3);
        start_fill(32'h0010_0000, 4, 0, 1, 1, 16'h001F, 32'h5);
        wait_idle("pix_even", 32'h4);

        // Clip at the right edge: pixels 630..639 -> words 315..319
        for (int i = 0; i < 5; i++) push(32'h0010_04EC + 32'(4 * i), 32'hFFFF_FFFF, 4'hF);
        start_fill(32'h0010_0000, 630, 0, 20, 1, 16'hFFFF, 32'h5);
        wait_idle("clip", 32'h4);

        // Reject x0 == H_RES: no writes, error and done
        start_fill(32'h0010_0000, 640, 0, 1, 1, 16'hFFFF, 32'h5);
        wait_idle("reject", 32'hC);
        chk("reject_nowr", 68'(acc_cnt), 68'd0);

        // Stall on the 2nd word; FB_BASE rewrite and a second go while busy are ignored
        for (int i = 0; i < 4; i++) push(32'h0020_0A00 + 32'(4 * i), 32'h1234_1234, 4'hF);
        stall_seen = 0;
        stall_at   = 1;
        stall_left = 5;
        start_fill(32'h0020_0000, 0, 2, 8, 1, 16'h1234, 32'h5);
        reg_wr(3'd1, 32'h0030_0000);
        reg_wr(3'd0, 32'h1);
        wait_idle("stall", 32'h4);
        chk("stall_cycles", 68'(stall_seen), 68'd5);
        chk("stall_count",  68'(acc_cnt), 68'd4);
        stall_at = -1;

        // Interrupt raised on done, dropped by clear
        push(32'h0010_0000, 32'hAAAA_AAAA, 4'hF);
        start_fill(32'h0010_0000, 0, 0, 2, 1, 16'hAAAA, 32'h7);
        wait_idle("irq", 32'h6);
        chk("irq_set", 68'(bus.irq), 68'd1);
        reg_wr(3'd0, 32'h6);
        chk("irq_clr", 68'(bus.irq), 68'd0);
        reg_rd(3'd0, r);
        chk("irq_status", 68'(r), 68'h2);

        // Reset in the middle of a full-width row
        for (int i = 0; i < 320; i++) push(32'h0010_0000 + 32'(4 * i), 32'h5555_5555, 4'hF);
        start_fill(32'h0010_0000, 0, 0, 640, 1, 16'h5555, 32'h1);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_active", 68'(bus.master_write), 68'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_write", 68'(bus.master_write), 68'd0);
        chk("mid_rst_addr",  68'(bus.master_address), 68'd0);
        chk("mid_rst_irq",   68'(bus.irq), 68'd0);
        reg_rd(3'd0, r);
        chk("mid_rst_ctrl",  68'(r), 68'd0);
        chk("mid_partial",   68'(acc_cnt), 68'd18);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_resume", 68'(acc_cnt), 68'd18);
        chk("no_resume_write", 68'(bus.master_write), 68'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
